pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the dual-issue pipeline (stages PC, IF, ID, OF, EX, MEM). Merges per-stage stall requests into one priority-encoded stall vector. Sequences exception/ERET redirection as a two-cycle freeze-then-flush handshake. Keeps stall and flush statistics for performance debug.

## Interface
- EXC_VECTOR, 32'hBFC00380, redirect PC for a non-ERET exception.
- CNT_W, 32, width of the stall-cycle counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high (`RstEnable` = 1).
- stallreq_if_i  in  1  IF request (instruction cache miss).
- stallreq_id_i  in  1  ID request (instruction buffer empty).
- stallreq_of_i  in  1  OF request (load-use dependency on EX slot 1).
- stallreq_ex_i  in  1  EX request (multi-cycle mul/div busy).
- stallreq_mem_i  in  1  MEM request (data cache miss).
- excp_valid_i  in  1  commit-stage exception or ERET present.
- excp_is_eret_i  in  1  qualifies excp_valid_i as ERET.
- cp0_epc_i  in  32  EPC value, used for ERET.
- stall_o  out  6  bit k freezes the stage k register (0 = PC … 5 = MEM).
- flush_o  out  1  clears every pipeline register and the instruction buffer.
- new_pc_o  out  32  redirect target, valid while flush_o = 1.
- stall_cycles_o  out  CNT_W  saturating count of cycles with stall_o[0] = 1.
- flush_count_o  out  16  wrapping count of flushes issued.
- last_cause_o  out  3  source of the most recent stall: 1 = IF, 2 = ID, 3 = OF, 4 = EX, 5 = MEM, 0 = none yet.

## Operation
- FSM states: RUN, FREEZE, FLUSH. Reset enters RUN.
- RUN, stall vector, highest source wins:
  - MEM → 6'b111111
  - EX → 6'b011111
  - OF → 6'b001111
  - ID → 6'b000111
  - IF → 6'b000011
  - none → 6'b000000
- Bubble rule: stall[k] = 1 with stall[k+1] = 0 means stage k+1 receives a bubble.
- RUN, exception accept: excp_valid_i = 1 and stallreq_mem_i = 0.
  - Latch target: cp0_epc_i if excp_is_eret_i, else EXC_VECTOR.
  - Go to FREEZE.
- RUN, exception with MEM stalled: excp_valid_i = 1 and stallreq_mem_i = 1.
  - Nothing is latched; the MEM stall vector applies.
  - The exception is accepted in the first cycle stallreq_mem_i drops (the commit stage holds excp_valid_i).
- Exception acceptance overrides EX/OF/ID/IF stalls in the same cycle.
- FREEZE: stall_o = 6'b111111, flush_o = 0. Next state FLUSH.
- FLUSH:
  - stall_o = 0, flush_o = 1, new_pc_o = latched target.
  - flush_count_o increments by 1, wrapping at 16 bits.
  - Next state RUN.
- All stall request inputs and excp_valid_i are ignored in FREEZE and FLUSH.
- new_pc_o outside FLUSH: 0.
- stall_cycles_o: +1 in every cycle where stall_o[0] = 1, in any state including FREEZE. Holds at all-ones.
- last_cause_o: updated in RUN whenever any stall source is active; holds otherwise.

## Timing
- stall_o is combinational from the request inputs in RUN and registered-state-driven in FREEZE/FLUSH. Zero latency from request to stall.
- Exception accepted in cycle N:
  - cycle N: stall_o = RUN vector.
  - cycle N+1: FREEZE, stall_o = 6'b111111.
  - cycle N+2: FLUSH, flush_o = 1, new_pc_o valid.
  - cycle N+3: RUN.
- flush_o is a single-cycle pulse. Back-to-back flushes are at least 3 cycles apart.
- Reset values:
  - state RUN
  - stall_o = 0, flush_o = 0, new_pc_o = 0
  - stall_cycles_o = 0, flush_count_o = 0, last_cause_o = 0
  - latched target = 0
- Reset asserted in FREEZE or FLUSH returns to RUN on that edge. No flush pulse is emitted after reset.
- Counters update on the edge that ends the qualifying cycle.

## Test plan
- Stall priority: stallreq_of_i = 1 and stallreq_if_i = 1 together → stall_o = 6'b001111, last_cause_o = 3 next cycle. Then add stallreq_mem_i = 1 → stall_o = 6'b111111, last_cause_o = 5.
- Exception accept: excp_valid_i = 1, excp_is_eret_i = 0 at cycle N → stall_o = 6'b111111 at N+1. At N+2, flush_o = 1 and new_pc_o = 32'hBFC00380. flush_count_o = 1 after N+2.
- ERET: cp0_epc_i = 32'h80001234 with excp_is_eret_i = 1 → new_pc_o = 32'h80001234 during the flush pulse.
- Exception under MEM stall: excp_valid_i = 1 with stallreq_mem_i = 1 for 4 cycles → no FREEZE while the stall lasts. FREEZE occurs the cycle after stallreq_mem_i drops. stall_cycles_o grows by 4 during the stall, plus 1 for FREEZE.
- Reset mid-sequence: rst = 1 in the FREEZE cycle → next cycle flush_o = 0, stall_o = 0, flush_count_o = 0, state RUN.
- Saturation: preload stall_cycles_o to within 2 of all-ones (CNT_W = 8 build), then hold stallreq_ex_i = 1 for 5 cycles → counter stops at 8'hFF and does not wrap.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges stage stall requests and runs the
// exception/ERET freeze-then-flush handshake, with perf counters.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if_i,
  input  logic             stallreq_id_i,
  input  logic             stallreq_of_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic             excp_valid_i,
  input  logic             excp_is_eret_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [15:0]      flush_count_o,
  output logic [2:0]       last_cause_o
);

  typedef enum logic [1:0] {
    RUN,
    FREEZE,
    FLUSH
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] target;
  logic [31:0] target_nxt;
  logic [5:0]  run_stall;
  logic [2:0]  run_cause;
  logic        any_req;

  assign any_req = stallreq_if_i | stallreq_id_i | stallreq_of_i |
                   stallreq_ex_i | stallreq_mem_i;

  // Deepest requesting stage wins: it freezes itself and everything upstream.
  always_comb begin
    run_stall = 6'b000000;
    run_cause = 3'd0;
    if (stallreq_mem_i) begin
      run_stall = 6'b111111;
      run_cause = 3'd5;
    end else if (stallreq_ex_i) begin
      run_stall = 6'b011111;
      run_cause = 3'd4;
    end else if (stallreq_of_i) begin
      run_stall = 6'b001111;
      run_cause = 3'd3;
    end else if (stallreq_id_i) begin
      run_stall = 6'b000111;
      run_cause = 3'd2;
    end else if (stallreq_if_i) begin
      run_stall = 6'b000011;
      run_cause = 3'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    stall_o    = 6'b000000;
    flush_o    = 1'b0;
    new_pc_o   = 32'd0;
    unique case (state)
      RUN: begin
        stall_o = run_stall;
        // A MEM stall defers acceptance; commit keeps excp_valid_i high.
        if (excp_valid_i && !stallreq_mem_i) begin
          state_nxt  = FREEZE;
          target_nxt = excp_is_eret_i ? cp0_epc_i : EXC_VECTOR;
        end
      end
      FREEZE: begin
        stall_o   = 6'b111111;
        state_nxt = FLUSH;
      end
      FLUSH: begin
        flush_o   = 1'b1;
        new_pc_o  = target;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      target         <= 32'd0;
      stall_cycles_o <= '0;
      flush_count_o  <= 16'd0;
      last_cause_o   <= 3'd0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      if (stall_o[0] && !(&stall_cycles_o))
        stall_cycles_o <= stall_cycles_o + CNT_W'(1);
      if (flush_o)
        flush_count_o <= flush_count_o + 16'd1;
      if (state == RUN && any_req)
        last_cause_o <= run_cause;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: priority table plus exception,
// ERET, MEM-deferred, reset-in-freeze and saturation sequences.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_of, req_ex, req_mem;
  logic        excp_valid, excp_eret;
  logic [31:0] epc;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic [2:0]  last_cause;

  logic [5:0]  stall8;
  logic        flush8;
  logic [31:0] new_pc8;
  logic [7:0]  stall_cycles8;
  logic [15:0] flush_count8;
  logic [2:0]  last_cause8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(req_if), .stallreq_id_i(req_id),
    .stallreq_of_i(req_of), .stallreq_ex_i(req_ex),
    .stallreq_mem_i(req_mem),
    .excp_valid_i(excp_valid), .excp_is_eret_i(excp_eret),
    .cp0_epc_i(epc),
    .stall_o(stall), .flush_o(flush), .new_pc_o(new_pc),
    .stall_cycles_o(stall_cycles), .flush_count_o(flush_count),
    .last_cause_o(last_cause)
  );

  pipeline_ctrl #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .stallreq_if_i(req_if), .stallreq_id_i(req_id),
    .stallreq_of_i(req_of), .stallreq_ex_i(req_ex),
    .stallreq_mem_i(req_mem),
    .excp_valid_i(excp_valid), .excp_is_eret_i(excp_eret),
    .cp0_epc_i(epc),
    .stall_o(stall8), .flush_o(flush8), .new_pc_o(new_pc8),
    .stall_cycles_o(stall_cycles8), .flush_count_o(flush_count8),
    .last_cause_o(last_cause8)
  );

  typedef struct {
    logic [4:0] req;
    logic [5:0] exp_stall;
    logic [2:0] exp_cause;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [4:0] r);
    {req_mem, req_ex, req_of, req_id, req_if} = r;
  endtask

  task automatic run_exc(input logic eret, input logic [31:0] pc,
                         input logic [31:0] exp_pc,
                         input logic [15:0] exp_cnt);
    set_req(5'b00000);
    excp_valid = 1'b1;
    excp_eret  = eret;
    epc        = pc;
    #1;
    chk("exc_n_stall", 32'(stall), 32'h00);
    chk("exc_n_flush", 32'(flush), 32'h0);
    tick();
    excp_valid = 1'b0;
    #1;
    chk("exc_freeze_stall", 32'(stall), 32'h3F);
    chk("exc_freeze_flush", 32'(flush), 32'h0);
    tick();
    #1;
    chk("exc_flush_pulse", 32'(flush), 32'h1);
    chk("exc_flush_stall", 32'(stall), 32'h00);
    chk("exc_new_pc", new_pc, exp_pc);
    tick();
    #1;
    chk("exc_after_flush", 32'(flush), 32'h0);
    chk("exc_after_pc", new_pc, 32'h0);
    chk("exc_flush_count", 32'(flush_count), 32'(exp_cnt));
  endtask

  initial begin
    vecs[0] = '{5'b00000, 6'b000000, 3'd0};
    vecs[1] = '{5'b00001, 6'b000011, 3'd1};
    vecs[2] = '{5'b00000, 6'b000000, 3'd1};
    vecs[3] = '{5'b00010, 6'b000111, 3'd2};
    vecs[4] = '{5'b00101, 6'b001111, 3'd3};
    vecs[5] = '{5'b10101, 6'b111111, 3'd5};
    vecs[6] = '{5'b01000, 6'b011111, 3'd4};
    vecs[7] = '{5'b11111, 6'b111111, 3'd5};
    vecs[8] = '{5'b00110, 6'b001111, 3'd3};

    rst        = 1'b1;
    excp_valid = 1'b0;
    excp_eret  = 1'b0;
    epc        = 32'd0;
    set_req(5'b00000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_stall_cycles", stall_cycles, 32'h0);
    chk("rst_flush_count", 32'(flush_count), 32'h0);
    chk("rst_last_cause", 32'(last_cause), 32'h0);
    chk("rst_stall_cycles8", 32'(stall_cycles8), 32'h0);

    for (int i = 0; i < 9; i++) begin
      set_req(vecs[i].req);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall),
          32'(vecs[i].exp_stall));
      tick();
      chk($sformatf("vec%0d_cause", i), 32'(last_cause),
          32'(vecs[i].exp_cause));
    end
    chk("table_stall_cycles", stall_cycles, 32'd7);

    run_exc(1'b0, 32'h12345678, 32'hBFC00380, 16'd1);
    chk("exc_stall_cycles", stall_cycles, 32'd8);
    run_exc(1'b1, 32'h80001234, 32'h80001234, 16'd2);
    chk("eret_stall_cycles", stall_cycles, 32'd9);

    excp_valid = 1'b1;
    excp_eret  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(5'b10000);
      #1;
      chk($sformatf("memx%0d_stall", i), 32'(stall), 32'h3F);
      chk($sformatf("memx%0d_flush", i), 32'(flush), 32'h0);
      tick();
    end
    chk("memx_cause", 32'(last_cause), 32'd5);
    set_req(5'b00000);
    #1;
    chk("memx_accept_stall", 32'(stall), 32'h00);
    tick();
    excp_valid = 1'b0;
    #1;
    chk("memx_freeze_stall", 32'(stall), 32'h3F);
    chk("memx_freeze_flush", 32'(flush), 32'h0);
    tick();
    #1;
    chk("memx_flush_pulse", 32'(flush), 32'h1);
    chk("memx_new_pc", new_pc, 32'hBFC00380);
    tick();
    #1;
    chk("memx_stall_cycles", stall_cycles, 32'd14);
    chk("memx_flush_count", 32'(flush_count), 32'd3);

    excp_valid = 1'b1;
    tick();
    excp_valid = 1'b0;
    rst        = 1'b1;
    #1;
    chk("rstf_freeze_stall", 32'(stall), 32'h3F);
    tick();
    rst = 1'b0;
    #1;
    chk("rstf_flush", 32'(flush), 32'h0);
    chk("rstf_stall", 32'(stall), 32'h0);
    chk("rstf_flush_count", 32'(flush_count), 32'h0);
    chk("rstf_stall_cycles", stall_cycles, 32'h0);
    chk("rstf_new_pc", new_pc, 32'h0);
    tick();
    #1;
    chk("rstf_no_pulse", 32'(flush), 32'h0);
    chk("rstf_run_stall", 32'(stall), 32'h0);

    set_req(5'b01000);
    repeat (253) tick();
    #1;
    chk("sat_preload", 32'(stall_cycles8), 32'hFD);
    repeat (5) tick();
    #1;
    chk("sat_hold", 32'(stall_cycles8), 32'hFF);
    chk("sat_cause", 32'(last_cause8), 32'd4);
    chk("wide_no_sat", stall_cycles, 32'd258);
    set_req(5'b00000);
    tick();
    #1;
    chk("sat_stays", 32'(stall_cycles8), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
